// File: rtl/spatz_vrf_responder.sv
// Banked 1R1W vector register file that serves NrPorts requesters. Each bank has
// its own read and write round-robin arbiter, and grants are combinational.
module spatz_vrf_responder #(
  parameter int unsigned NrPorts   = 3,
  parameter int unsigned NrWords   = 128,
  parameter int unsigned NrBanks   = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = $clog2(NrWords)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NrPorts*AddrWidth-1:0]     raddr_i,
  input  logic [NrPorts-1:0]               re_i,
  output logic [NrPorts*DataWidth-1:0]     rdata_o,
  output logic [NrPorts-1:0]               rvalid_o,
  input  logic [NrPorts*AddrWidth-1:0]     waddr_i,
  input  logic [NrPorts*DataWidth-1:0]     wdata_i,
  input  logic [NrPorts*DataWidth/8-1:0]   wbe_i,
  input  logic [NrPorts-1:0]               we_i,
  output logic [NrPorts-1:0]               wvalid_o,
  output logic [15:0]                      rd_conflicts_o,
  output logic [15:0]                      wr_conflicts_o
);

  localparam int unsigned NrBytes  = DataWidth / 8;
  localparam int unsigned PtrWidth = (NrPorts > 1) ? $clog2(NrPorts) : 1;

  typedef logic [PtrWidth-1:0] ptr_t;

  logic [DataWidth-1:0] mem_q [NrWords];
  ptr_t                 rd_ptr_q [NrBanks];
  ptr_t                 rd_ptr_d [NrBanks];
  ptr_t                 wr_ptr_q [NrBanks];
  ptr_t                 wr_ptr_d [NrBanks];
  logic [NrPorts-1:0]   rd_bank_grant [NrBanks];
  logic [NrPorts-1:0]   wr_bank_grant [NrBanks];
  logic [NrPorts-1:0]   rgrant;
  logic [NrPorts-1:0]   wgrant;
  logic [15:0]          rd_cnt_q, rd_cnt_d;
  logic [15:0]          wr_cnt_q, wr_cnt_d;

  // Banks are low-order interleaved, so the bank index is the address modulo NrBanks.
  function automatic int unsigned bank_of(input logic [AddrWidth-1:0] addr);
    return 32'(addr) % NrBanks;
  endfunction

  // Grant the first requester of bank b at or after ptr, wrapping around.
  function automatic logic [NrPorts-1:0] pick(input logic [NrPorts-1:0]           req,
                                              input logic [NrPorts*AddrWidth-1:0] addr,
                                              input ptr_t                         ptr,
                                              input int unsigned                  b);
    logic [NrPorts-1:0] g;
    logic               found;
    int unsigned        p;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NrPorts; k++) begin
      p = (32'(ptr) + k) % NrPorts;
      if (!found && req[p] && (bank_of(addr[p*AddrWidth +: AddrWidth]) == b)) begin
        g[p]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic ptr_t next_ptr(input logic [NrPorts-1:0] g, input ptr_t ptr);
    ptr_t np;
    np = ptr;
    for (int unsigned p = 0; p < NrPorts; p++) begin
      if (g[p]) np = ptr_t'((p + 1) % NrPorts);
    end
    return np;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [NrPorts-1:0] denied);
    logic [16:0] sum;
    sum = {1'b0, cnt};
    for (int unsigned p = 0; p < NrPorts; p++) begin
      sum = sum + 17'(denied[p]);
    end
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Read arbitration looks only at the read inputs, and write arbitration only at the
  // write inputs. This lets a requester drive we from rvalid without forming a loop.
  always_comb begin
    rgrant = '0;
    wgrant = '0;
    for (int unsigned b = 0; b < NrBanks; b++) begin
      rd_bank_grant[b] = pick(re_i, raddr_i, rd_ptr_q[b], b);
      wr_bank_grant[b] = pick(we_i, waddr_i, wr_ptr_q[b], b);
      rd_ptr_d[b]      = next_ptr(rd_bank_grant[b], rd_ptr_q[b]);
      wr_ptr_d[b]      = next_ptr(wr_bank_grant[b], wr_ptr_q[b]);
      rgrant           = rgrant | rd_bank_grant[b];
      wgrant           = wgrant | wr_bank_grant[b];
    end
  end

  assign rvalid_o = rst_i ? '0 : rgrant;
  assign wvalid_o = rst_i ? '0 : wgrant;

  always_comb begin
    rdata_o = '0;
    for (int unsigned p = 0; p < NrPorts; p++) begin
      if (rvalid_o[p]) rdata_o[p*DataWidth +: DataWidth] = mem_q[raddr_i[p*AddrWidth +: AddrWidth]];
    end
  end

  assign rd_cnt_d = sat_add(rd_cnt_q, re_i & ~rgrant);
  assign wr_cnt_d = sat_add(wr_cnt_q, we_i & ~wgrant);

  assign rd_conflicts_o = rd_cnt_q;
  assign wr_conflicts_o = wr_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned b = 0; b < NrBanks; b++) begin
        rd_ptr_q[b] <= '0;
        wr_ptr_q[b] <= '0;
      end
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // At most one write is granted per bank, so two ports never update the same word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned w = 0; w < NrWords; w++) mem_q[w] <= '0;
    end else begin
      for (int unsigned p = 0; p < NrPorts; p++) begin
        if (wgrant[p]) begin
          for (int unsigned i = 0; i < NrBytes; i++) begin
            if (wbe_i[p*NrBytes + i]) begin
              mem_q[waddr_i[p*AddrWidth +: AddrWidth]][i*8 +: 8] <= wdata_i[p*DataWidth + i*8 +: 8];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spatz_vrf_responder.sv
// Randomised and directed bench for spatz_vrf_responder. A reference model predicts
// each cycle, and a negedge monitor compares the DUT outputs against a queue.
module tb_spatz_vrf_responder;

  localparam int NP  = 3;
  localparam int NW  = 128;
  localparam int NB  = 4;
  localparam int DW  = 64;
  localparam int AW  = 7;
  localparam int NBY = DW / 8;

  logic              clk, rst;
  logic [NP*AW-1:0]  raddr_d, waddr_d;
  logic [NP-1:0]     re_d, we_d, we_i, rvalid_o, wvalid_o;
  logic [NP*DW-1:0]  wdata_d, rdata_o;
  logic [NP*NBY-1:0] wbe_d;
  logic [15:0]       rd_conflicts_o, wr_conflicts_o;
  logic              slide_mode;

  // In slide mode, port 0 issues a write exactly when its read is granted.
  assign we_i = slide_mode ? {{(NP-1){1'b0}}, rvalid_o[0]} : we_d;

  spatz_vrf_responder #(.NrPorts(NP), .NrWords(NW), .NrBanks(NB), .DataWidth(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .raddr_i(raddr_d), .re_i(re_d), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .waddr_i(waddr_d), .wdata_i(wdata_d), .wbe_i(wbe_d), .we_i(we_i), .wvalid_o(wvalid_o),
    .rd_conflicts_o(rd_conflicts_o), .wr_conflicts_o(wr_conflicts_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NP-1:0]    rv;
    logic [NP-1:0]    wv;
    logic [NP*DW-1:0] rd;
    logic [15:0]      rc;
    logic [15:0]      wc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] mem_m [NW];
  int            rd_ptr_m [NB];
  int            wr_ptr_m [NB];
  int            rc_m, wc_m;

  task automatic chk(input string name, input logic [NP*DW-1:0] act, input logic [NP*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < NW; w++) mem_m[w] = '0;
    for (int b = 0; b < NB; b++) begin
      rd_ptr_m[b] = 0;
      wr_ptr_m[b] = 0;
    end
    rc_m = 0;
    wc_m = 0;
  endtask

  // For each bank, the winner is the requester at the smallest rotational distance from the pointer.
  task automatic arb(input logic [NP-1:0] req, input logic [NP*AW-1:0] addr, input bit is_wr,
                     output logic [NP-1:0] g);
    int ptr, best, bestd, d;
    g = '0;
    for (int b = 0; b < NB; b++) begin
      ptr   = is_wr ? wr_ptr_m[b] : rd_ptr_m[b];
      best  = -1;
      bestd = NP;
      for (int p = 0; p < NP; p++) begin
        d = (p - ptr + NP) % NP;
        if (req[p] && (int'(addr[p*AW +: AW]) % NB == b) && d < bestd) begin
          best  = p;
          bestd = d;
        end
      end
      if (best >= 0) begin
        g[best] = 1'b1;
        if (is_wr) wr_ptr_m[b] = (best + 1) % NP;
        else       rd_ptr_m[b] = (best + 1) % NP;
      end
    end
  endtask

  // Predict the current cycle, queue the prediction, apply the writes, then advance one clock.
  task automatic step();
    logic [NP-1:0]    rg, wg, we_eff;
    logic [NP*DW-1:0] rd;
    exp_t             e;
    int               a;
    arb(re_d, raddr_d, 1'b0, rg);
    we_eff = slide_mode ? {{(NP-1){1'b0}}, rg[0]} : we_d;
    arb(we_eff, waddr_d, 1'b1, wg);
    rd = '0;
    for (int p = 0; p < NP; p++)
      if (rg[p]) rd[p*DW +: DW] = mem_m[int'(raddr_d[p*AW +: AW])];
    e.rv = rg;
    e.wv = wg;
    e.rd = rd;
    e.rc = 16'(rc_m);
    e.wc = 16'(wc_m);
    exp_q.push_back(e);
    for (int p = 0; p < NP; p++) begin
      if (wg[p]) begin
        a = int'(waddr_d[p*AW +: AW]);
        for (int i = 0; i < NBY; i++)
          if (wbe_d[p*NBY + i]) mem_m[a][i*8 +: 8] = wdata_d[p*DW + i*8 +: 8];
      end
    end
    rc_m = rc_m + $countones(re_d & ~rg);
    wc_m = wc_m + $countones(we_eff & ~wg);
    if (rc_m > 65535) rc_m = 65535;
    if (wc_m > 65535) wc_m = 65535;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    re_d = '0; we_d = '0; raddr_d = '0; waddr_d = '0; wdata_d = '0; wbe_d = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    re_d[p] = 1'b1;
    raddr_d[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int p, input int a, input logic [DW-1:0] d, input logic [NBY-1:0] be);
    we_d[p] = 1'b1;
    waddr_d[p*AW +: AW] = AW'(a);
    wdata_d[p*DW +: DW] = d;
    wbe_d[p*NBY +: NBY] = be;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rvalid"}, NP*DW'(rvalid_o), '0);
    chk({tag, "_wvalid"}, NP*DW'(wvalid_o), '0);
    chk({tag, "_rdata"}, rdata_o, '0);
    chk({tag, "_rdconf"}, NP*DW'(rd_conflicts_o), '0);
    chk({tag, "_wrconf"}, NP*DW'(wr_conflicts_o), '0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rvalid", NP*DW'(rvalid_o), NP*DW'(e.rv));
      chk("wvalid", NP*DW'(wvalid_o), NP*DW'(e.wv));
      chk("rdata", rdata_o, e.rd);
      chk("rd_conflicts", NP*DW'(rd_conflicts_o), NP*DW'(e.rc));
      chk("wr_conflicts", NP*DW'(wr_conflicts_o), NP*DW'(e.wc));
    end
  end

  initial begin
    slide_mode = 1'b0;
    rst = 1'b1;
    idle();
    re_d = '1; we_d = '1; wbe_d = '1; raddr_d = {7'd8, 7'd4, 7'd0};
    #1;
    check_zero("reset");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Read of a cleared word, then a full write, then read back.
    idle(); set_rd(0, 5); step();
    idle(); set_wr(0, 5, 64'hDEAD_BEEF_0123_4567, 8'hFF); step();
    idle(); set_rd(0, 5); step();

    // Partial byte-enable write.
    idle(); set_wr(0, 9, '1, 8'h0F); step();
    idle(); set_rd(0, 9); step();

    // A read and write of the same word in one cycle return the old data.
    idle(); set_wr(0, 12, 64'd1, 8'hFF); step();
    idle(); set_rd(0, 12); set_wr(0, 12, 64'd2, 8'hFF); step();
    idle(); set_rd(0, 12); step();

    // Three readers persistently contend for bank 0.
    repeat (6) begin
      idle(); set_rd(0, 0); set_rd(1, 4); set_rd(2, 8); step();
    end
    idle(); set_rd(0, 1); set_rd(1, 2); set_rd(2, 3); step();

    // Slide-style loop in which we follows rvalid and the write goes to another bank.
    slide_mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      idle(); set_rd(0, i); set_wr(0, (i + 65) % NW, 64'(i + 100), 8'hFF); step();
    end
    slide_mode = 1'b0;

    // Reset asserted in the middle of a burst of pending writes.
    idle();
    for (int p = 0; p < NP; p++) begin
      set_rd(p, 4 * p); set_wr(p, 4 * p, {$urandom, $urandom}, 8'hFF);
    end
    step();
    #2;
    rst = 1'b1;
    #1;
    check_zero("midreset");
    model_reset();
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      idle(); set_rd(0, 0); set_rd(1, 4); set_rd(2, 8); step();
    end
    idle(); set_rd(0, 5); set_rd(1, 9); set_rd(2, 12); step();

    // Random traffic, biased toward low addresses so that conflicts occur.
    repeat (400) begin
      idle();
      re_d = NP'($urandom);
      we_d = NP'($urandom);
      for (int p = 0; p < NP; p++) begin
        raddr_d[p*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 15) : $urandom_range(0, NW - 1));
        waddr_d[p*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 15) : $urandom_range(0, NW - 1));
        wdata_d[p*DW +: DW] = {$urandom, $urandom};
        wbe_d[p*NBY +: NBY] = NBY'($urandom);
      end
      step();
    end

    idle();
    #10;
    chk("drain", NP*DW'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
